// File: rtl/command_frame_pkg.sv
// Shared types and constants for the command frame decoder and its users
// (controller benches import this to build frames).
package command_frame_pkg;

  localparam int unsigned FRAME_LEN  = 8;
  localparam int unsigned ADDR_BYTES = 2;
  localparam int unsigned DATA_BYTES = 4;
  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned IDX_WIDTH  = $clog2(FRAME_LEN);

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    CSUM,
    EMIT
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/command_frame_decoder.sv
// Byte-stream to single-cycle register-write bridge with XOR-checked 8-byte frames.
// Optional inter-byte timeout: define COMMAND_FRAME_DECODER_TIMEOUT_EN.
module command_frame_decoder
  import command_frame_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned COUNT_WIDTH    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [7:0]             byte_i,
  input  logic                   byte_valid_i,
  output logic                   byte_ready_o,
  output logic [ADDR_WIDTH-1:0]  out_addr_o,
  output logic [DATA_WIDTH-1:0]  out_data_o,
  output logic                   out_valid_o,
  output logic [COUNT_WIDTH-1:0] frame_count_o,
  output logic [COUNT_WIDTH-1:0] error_count_o,
  output logic [COUNT_WIDTH-1:0] timeout_count_o
);

  state_e                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [7:0]             xor_q, xor_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [ADDR_WIDTH-1:0]  out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   accept;
  logic                   timeout_fire;
  logic                   frame_inc;
  logic                   err_inc;

  assign byte_ready_o = !rst_i && (state_q != EMIT);
  assign accept       = byte_valid_i && byte_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      xor_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      xor_q       <= xor_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Frame sequencing; SYNC_BYTE only resynchronises from IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    xor_d   = xor_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (accept && (byte_i == SYNC_BYTE)) begin
          state_d = ADDR;
          idx_d   = '0;
          xor_d   = '0;
        end
      end
      ADDR: begin
        if (accept) begin
          addr_d = {addr_q[ADDR_WIDTH-9:0], byte_i};
          xor_d  = xor_q ^ byte_i;
          if (idx_q == IDX_WIDTH'(ADDR_BYTES - 1)) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end else if (timeout_fire) begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (accept) begin
          data_d = {data_q[DATA_WIDTH-9:0], byte_i};
          xor_d  = xor_q ^ byte_i;
          if (idx_q == IDX_WIDTH'(DATA_BYTES - 1)) begin
            state_d = CSUM;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end else if (timeout_fire) begin
          state_d = IDLE;
        end
      end
      CSUM: begin
        if (accept) begin
          state_d = (byte_i == xor_q) ? EMIT : IDLE;
        end else if (timeout_fire) begin
          state_d = IDLE;
        end
      end
      EMIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write-port load and status-counter strobes.
  always_comb begin
    out_valid_d = (state_d == EMIT);
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    if (state_d == EMIT) begin
      out_addr_d = addr_q;
      out_data_d = data_q;
    end
    frame_inc = (state_q == EMIT);
    err_inc   = (state_q == CSUM) && accept && (byte_i != xor_q);
  end

  assign out_addr_o  = out_addr_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_frame_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (1'b0),
    .inc_i   (frame_inc),
    .count_o (frame_count_o)
  );

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_error_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (1'b0),
    .inc_i   (err_inc),
    .count_o (error_count_o)
  );

`ifdef COMMAND_FRAME_DECODER_TIMEOUT_EN
  localparam int unsigned GAP_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;

  logic [GAP_WIDTH-1:0] gap_q;
  logic                 in_payload;

  assign in_payload   = (state_q == ADDR) || (state_q == DATA) || (state_q == CSUM);
  assign timeout_fire = in_payload && !accept && (gap_q == GAP_WIDTH'(TIMEOUT_CYCLES - 1));

  // Idle-cycle count inside a frame; an accepted byte always wins over expiry.
  always_ff @(posedge clk_i) begin
    if (rst_i || accept || !in_payload || (state_d == IDLE)) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_q + GAP_WIDTH'(1);
    end
  end

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_timeout_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (1'b0),
    .inc_i   (timeout_fire),
    .count_o (timeout_count_o)
  );
`else
  assign timeout_fire    = 1'b0;
  assign timeout_count_o = '0;
`endif

endmodule
